// File: rtl/dac_pkg.sv
// Shared definitions for the sigma-delta DAC path: oversampling and accumulator
// width helpers, plus the signed sample range used by interpolator and modulator.
`timescale 1ns/1ps
package dac_pkg;

    localparam int DAC_BW = 16;
    localparam logic signed [DAC_BW-1:0] SAMPLE_MIN = 16'sh8000;
    localparam logic signed [DAC_BW-1:0] SAMPLE_MAX = 16'sh7FFF;

    function automatic int osr_of(input int log2_osr);
        return 1 << log2_osr;
    endfunction

    // Accumulator holds prev*OSR plus up to OSR-1 steps of diff.
    function automatic int acc_width(input int bw, input int log2_osr);
        return bw + log2_osr;
    endfunction

endpackage

// File: rtl/dac_in_buf.sv
// One-entry input holding register. Valid/ready: a word moves when
// in_valid_i && in_ready_o on a rising edge; in_ready_o is simply !buf_valid_o.
`timescale 1ns/1ps
module dac_in_buf #(
    parameter int BW = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [BW-1:0] in_data_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic          consume_i,
    output logic [BW-1:0] buf_data_o,
    output logic          buf_valid_o
);

    assign in_ready_o = !buf_valid_o;

    // Consume only happens while full and accept only while empty, so they never collide.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            buf_data_o  <= '0;
            buf_valid_o <= 1'b0;
        end else if (consume_i) begin
            buf_valid_o <= 1'b0;
        end else if (in_valid_i && in_ready_o) begin
            buf_data_o  <= in_data_i;
            buf_valid_o <= 1'b1;
        end
    end

endmodule

// File: rtl/dac_lin_interp.sv
// Linear-interpolating upsampler feeding the sigma-delta modulator: ramps from
// prev to next over OSR clocks, one registered output sample per clock.
`timescale 1ns/1ps
module dac_lin_interp
    import dac_pkg::*;
#(
    parameter int BW       = 16,
    parameter int LOG2_OSR = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [BW-1:0]       in_data_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic                clr_under_i,
    output logic [BW-1:0]       sample_o,
    output logic [LOG2_OSR-1:0] phase_o,
    output logic                underrun_o
);

    localparam int OSR = osr_of(LOG2_OSR);
    localparam int AW  = acc_width(BW, LOG2_OSR);

    logic signed [BW-1:0]   prev_q;
    logic signed [BW-1:0]   next_q;
    logic signed [AW-1:0]   acc_q;
    logic signed [AW-1:0]   diff;
    logic [LOG2_OSR-1:0]    phase_q;
    logic [BW-1:0]          buf_data;
    logic                   buf_valid;
    logic                   boundary;
    logic                   consume;

    dac_in_buf #(.BW(BW)) u_in_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_data_i   (in_data_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .consume_i   (consume),
        .buf_data_o  (buf_data),
        .buf_valid_o (buf_valid)
    );

    assign boundary = (phase_q == LOG2_OSR'(OSR - 1));
    assign consume  = boundary && buf_valid;
    assign diff     = $signed({{LOG2_OSR{next_q[BW-1]}}, next_q})
                    - $signed({{LOG2_OSR{prev_q[BW-1]}}, prev_q});

    // acc = prev*OSR + phase*diff, so its top BW bits are floor-interpolated.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            prev_q  <= '0;
            next_q  <= '0;
            acc_q   <= '0;
            phase_q <= '0;
        end else if (boundary) begin
            phase_q <= '0;
            prev_q  <= next_q;
            acc_q   <= $signed({next_q, {LOG2_OSR{1'b0}}});
            if (buf_valid) begin
                next_q <= $signed(buf_data);
            end
        end else begin
            phase_q <= phase_q + 1'b1;
            acc_q   <= acc_q + diff;
        end
    end

    // An underrun in the same cycle as a clear request wins.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            underrun_o <= 1'b0;
        end else if (boundary && !buf_valid) begin
            underrun_o <= 1'b1;
        end else if (clr_under_i) begin
            underrun_o <= 1'b0;
        end
    end

    assign sample_o = acc_q[AW-1:LOG2_OSR];
    assign phase_o  = phase_q;

endmodule
